// File: rtl/wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wrr_arbiter
// Brief    : N-way weighted round-robin arbiter with registered one-hot grant,
//            encoded grant index and multi-beat tenure. Optional macro
//            WRR_LOCK_EN adds a lock input that freezes tenure accounting.
// Revision : 1.0 - initial release
// ============================================================================
module wrr_arbiter #(
  parameter  int N  = 4,
  parameter  int WW = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [N-1:0]    request,
  input  logic [N*WW-1:0] weight,
`ifdef WRR_LOCK_EN
  input  logic            lock,
`endif
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [WW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  credit_q, credit_d;

  logic [IW-1:0]  next_idx;
  logic [IW-1:0]  search_start;
  logic [IW-1:0]  sel;
  logic [WW-1:0]  sel_weight;
  logic           lock_hold;
  logic           rel;
  logic           do_grant;

`ifdef WRR_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign next_idx     = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
  // After a release the search starts just past the old owner; from IDLE it starts at ptr.
  assign search_start = (state_q == OWNED) ? next_idx : ptr_q;

  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (request[(int'(search_start) + k) % N]) begin
        sel = IW'((int'(search_start) + k) % N);
      end
    end
  end

  always_comb begin
    sel_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        sel_weight = weight[i*WW +: WW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    credit_d = credit_q;
    rel      = 1'b0;
    do_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (|request) begin
          do_grant = 1'b1;
        end
      end
      OWNED: begin
        if (!request[idx_q]) begin
          rel = 1'b1;
        end else if (!lock_hold) begin
          if ((cnt_q + WW'(1)) == credit_q) begin
            rel = 1'b1;
          end else begin
            cnt_d = cnt_q + WW'(1);
          end
        end
        if (rel) begin
          ptr_d = next_idx;
          if (|request) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase

    if (do_grant) begin
      state_d  = OWNED;
      grant_d  = N'(1) << sel;
      idx_d    = sel;
      cnt_d    = '0;
      // A zero weight still buys a single beat.
      credit_d = (sel_weight == '0) ? WW'(1) : sel_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrr_arbiter
// Brief    : Directed self-checking bench for wrr_arbiter (N=4, WW=4).
//            Lock scenario is built only when WRR_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wrr_arbiter;

  logic        clk;
  logic        rst_b;
  logic [3:0]  request;
  logic [15:0] weight;
`ifdef WRR_LOCK_EN
  logic        lock;
`endif
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_valid;

  int checks = 0;
  int errors = 0;

  wrr_arbiter #(.N(4), .WW(4)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .request     (request),
    .weight      (weight),
`ifdef WRR_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    logic ev;
    ev = |eg;
    checks++;
    assert (grant === eg) else begin
      errors++;
      $error("FAIL %s grant observed=%b expected=%b", tag, grant, eg);
    end
    checks++;
    assert (grant_idx === ei) else begin
      errors++;
      $error("FAIL %s grant_idx observed=%0d expected=%0d", tag, grant_idx, ei);
    end
    checks++;
    assert (grant_valid === ev) else begin
      errors++;
      $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, ev);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b   = 1'b0;
    request = 4'b1111;
    weight  = 16'h1111;
`ifdef WRR_LOCK_EN
    lock    = 1'b0;
`endif

    // Reset held with all requesters active
    step(); chk("rst_hold_a", 4'b0000, 2'd0);
    step(); chk("rst_hold_b", 4'b0000, 2'd0);

    // Equal weights, two requesters alternate
    rst_b   = 1'b1;
    request = 4'b0011;
    step(); chk("rr_e1", 4'b0001, 2'd0);
    step(); chk("rr_e2", 4'b0010, 2'd1);
    step(); chk("rr_e3", 4'b0001, 2'd0);
    step(); chk("rr_e4", 4'b0010, 2'd1);

    // weight0=3, weight1=1
    weight = 16'h1113;
    step(); chk("w3_b1", 4'b0001, 2'd0);
    step(); chk("w3_b2", 4'b0001, 2'd0);
    step(); chk("w3_b3", 4'b0001, 2'd0);
    step(); chk("w3_r1", 4'b0010, 2'd1);
    step(); chk("w3_back", 4'b0001, 2'd0);

    // Asynchronous reset between edges
    #2 rst_b = 1'b0;
    #1 chk("async_rst", 4'b0000, 2'd0);
    step(); chk("async_rst_held", 4'b0000, 2'd0);

    // Early release and wrap-around
    weight  = 16'h1411;
    request = 4'b0100;
    rst_b   = 1'b1;
    step(); chk("er_g2a", 4'b0100, 2'd2);
    step(); chk("er_g2b", 4'b0100, 2'd2);
    request = 4'b1000;
    step(); chk("er_g3", 4'b1000, 2'd3);
    request = 4'b1001;
    step(); chk("wrap_g0", 4'b0001, 2'd0);

    // Weight 0 behaves as a single beat
    weight  = 16'h1401;
    request = 4'b0010;
    step(); chk("w0_a", 4'b0010, 2'd1);
    step(); chk("w0_regrant", 4'b0010, 2'd1);
    request = 4'b0011;
    step(); chk("w0_pass", 4'b0001, 2'd0);
    request = 4'b0000;
    step(); chk("idle_a", 4'b0000, 2'd0);
    step(); chk("idle_b", 4'b0000, 2'd0);

`ifdef WRR_LOCK_EN
    rst_b = 1'b0;
    step();
    weight  = 16'h1111;
    request = 4'b0011;
    lock    = 1'b1;
    rst_b   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(); chk("lock_hold", 4'b0001, 2'd0);
    end
    lock = 1'b0;
    step(); chk("lock_drop", 4'b0010, 2'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter. It is the successor to the fixed 4-requester round-robin arbiter: N requesters, per-requester weights (multi-beat tenure) and a registered one-hot grant with an encoded index. It sits between N request sources and one shared resource, such as a bus port or a memory bank.

Parameters:
N, 4, number of requesters (>=2)
WW, 4, width in bits of each requester's weight field
IW, $clog2(N), width of grant_idx (derived, not overridden)

Ports:
clk  input  1  clock, rising-edge active
rst_b  input  1  asynchronous active-low reset
request  input  N  request[i] high = requester i wants the resource
weight  input  N*WW  weight of requester i in bits [i*WW +: WW]; quasi-static, sampled when a grant is issued
grant  output  N  registered one-hot grant, or all zero
grant_idx  output  IW  binary index of the current owner; 0 when idle
grant_valid  output  1  equals |grant
lock  input  1  present only with WRR_LOCK_EN

Behaviour:
- Reset (rst_b low, asynchronous): grant=0, grant_idx=0, grant_valid=0, ptr=0, beat counter=0, state=IDLE. All of these are held while rst_b is low.
- State machine has two states, IDLE and OWNED.
- Beat: a rising edge at which grant[i]=1 and request[i]=1, where i is the owner.
- Credit: the weight of the owner, latched at grant time. Weight 0 is treated as 1.
- IDLE:
  - At an edge with request==0, stay in IDLE.
  - Otherwise, grant the first requester found searching cyclically upward from ptr.
  - Latch its credit and clear the beat counter. Go to OWNED.
  - Latency is 1 cycle: a request visible at edge k gives a grant after edge k.
- OWNED (owner i), release conditions, evaluated at each edge:
  - request[i]=0 at that edge (early release, the edge is not a beat), or
  - the edge is the credit-th beat.
- OWNED, no release: increment the beat counter on each beat; grant is unchanged.
- On release, on the same edge (no idle bubble):
  - ptr := (i+1) mod N.
  - Pick the new owner from the request vector sampled at that edge, searching from (i+1) mod N.
  - If the only requester is i, re-grant i with fresh credit.
  - If no request is present, go to IDLE with grant=0.
- Wrap-around: the search from N-1 continues at 0. ptr wraps modulo N.
- grant is always one-hot or zero, and changes only on rising clk or on reset assertion.
- Weight changes mid-tenure have no effect until the next grant.
- Beat counter is WW bits wide. The maximum tenure is 2^WW-1 beats.
- Reset mid-tenure: grant clears immediately. After rst_b rises, arbitration restarts from ptr=0.

Optional Feature:
WRR_LOCK_EN
- Defined:
  - Adds input lock.
  - While lock=1 and request[i]=1 for owner i, beats are not counted and credit exhaustion does not release the grant. This allows atomic sequences.
  - Dropping request[i] still releases, regardless of lock.
  - When lock falls, counting resumes from the held beat count.
- Not defined:
  - No lock port exists.
  - Tenure is bounded purely by weight and request.

Test Plan:
1. Reset: rst_b=0 with request=4'b1111 -> grant=0000, grant_valid=0, grant_idx=0 throughout. Assert rst_b low asynchronously between edges -> grant clears before the next edge.
2. N=4, all weights 1, request=4'b0011 held from the first edge after reset -> grant 0001, 0010, 0001, 0010 on consecutive cycles; grant_idx 0,1,0,1.
3. weight0=3, weight1=1, request=0011 held -> grant 0001 for 3 cycles, then 0010 for 1 cycle, repeating; no idle cycle between owners.
4. weight2=4, request=0100 for 2 cycles, then request=1000 -> grant 0100 for 2 cycles, then 1000 on the edge request[2] drops. Next search starts at requester 3; continued request=1001 -> after 1000 releases, grant 0001 (wrap).
5. Weight 0 for requester 1, request=0010 held -> grant stays 0010 with 1-beat re-grants. Then request=0000 -> grant=0000 after the next edge, state IDLE.
6. WRR_LOCK_EN, weight0=1, request=0011, lock=1 for 5 cycles -> grant 0001 held all 5 cycles. lock=0 -> grant moves to 0010 at the next edge.
